// File: rtl/stage_seq_pkg.sv
// Shared types, stage indices and next-stage selection for the stage sequencer.
package stage_seq_pkg;

    localparam int unsigned MAX_STAGES  = 16;
    localparam int unsigned MAX_STAGE_W = 4;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic                   valid;
        logic [MAX_STAGE_W-1:0] idx;
    } stage_sel_t;

    // Lowest stage above 'stage' (and below 'num') whose skip bit is clear; valid=0 means retire.
    function automatic stage_sel_t next_stage(
        input logic [MAX_STAGE_W-1:0] stage,
        input logic [MAX_STAGES-1:0]  mask,
        input logic [MAX_STAGE_W:0]   num
    );
        stage_sel_t sel;
        sel = '0;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if ((i > int'(stage)) && (i < int'(num)) && !mask[i]) begin
                sel.valid = 1'b1;
                sel.idx   = MAX_STAGE_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/stage_dwell_counter.sv
// Per-stage dwell counter: counts non-stalled cycles, flags the final dwell cycle.
module stage_dwell_counter #(
    parameter int unsigned WAIT_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_hold,
    input  logic [WAIT_W-1:0] i_wait,
    output logic              o_done
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            cnt <= '0;
        end else if (!i_hold) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

    assign o_done = (cnt == i_wait);

endmodule

// File: rtl/stage_sequencer.sv
// One-hot stage-enable sequencer with dwell, skip, stall, flush, halt and retire count.
// Optional STAGE_SEQUENCER_PERF_EN adds RUN-cycle and stall-cycle counters.
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int unsigned                 NUM_STAGES = 5,
    parameter int unsigned                 WAIT_W     = 4,
    parameter logic [NUM_STAGES*WAIT_W-1:0] STAGE_WAIT = '0,
    parameter int unsigned                 CNT_W      = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic                          i_stall,
    input  logic                          i_flush,
    input  logic                          i_halt,
    input  logic [NUM_STAGES-1:0]         i_skip_mask,
    output logic [NUM_STAGES-1:0]         o_en,
    output logic [NUM_STAGES-1:0]         o_busy,
    output logic [$clog2(NUM_STAGES)-1:0] o_stage,
    output logic                          o_retire,
    output logic [CNT_W-1:0]              o_instret,
    output logic                          o_halted
`ifdef STAGE_SEQUENCER_PERF_EN
    ,
    output logic [CNT_W-1:0]              o_cycles,
    output logic [CNT_W-1:0]              o_stall_cycles
`endif
);

    localparam int unsigned SW = $clog2(NUM_STAGES);

    seq_state_t        state;
    logic [SW-1:0]     stage;
    logic              halt_pending;
    logic [CNT_W-1:0]  instret;

    logic              run;
    logic              dwell_done;
    logic              dwell_clear;
    logic              en_fire;
    logic [WAIT_W-1:0] wait_cur;
    logic [NUM_STAGES-1:0] stage_onehot;
    stage_sel_t        sel;

    // Decodes from registered state plus this cycle's control inputs.
    always_comb begin
        run          = (state == RUN);
        wait_cur     = STAGE_WAIT[int'(stage)*WAIT_W +: WAIT_W];
        sel          = next_stage(MAX_STAGE_W'(stage), MAX_STAGES'(i_skip_mask),
                                  (MAX_STAGE_W+1)'(NUM_STAGES));
        stage_onehot = NUM_STAGES'(1) << stage;
        en_fire      = run && !i_flush && !i_stall && dwell_done;
        dwell_clear  = !run || i_flush || en_fire;
    end

    stage_dwell_counter #(
        .WAIT_W (WAIT_W)
    ) u_dwell (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (dwell_clear),
        .i_hold  (i_stall),
        .i_wait  (wait_cur),
        .o_done  (dwell_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            stage        <= SW'(STG_IF);
            halt_pending <= 1'b0;
            instret      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= RUN;
                        stage <= SW'(STG_IF);
                    end
                end
                RUN: begin
                    if (i_flush) begin
                        // A halt request arriving with the flush survives it.
                        stage        <= SW'(STG_IF);
                        halt_pending <= i_halt;
                    end else begin
                        if (i_halt) begin
                            halt_pending <= 1'b1;
                        end
                        if (en_fire) begin
                            if (sel.valid) begin
                                stage <= SW'(sel.idx);
                            end else begin
                                instret <= instret + CNT_W'(1);
                                stage   <= SW'(STG_IF);
                                if (halt_pending || i_halt) begin
                                    state        <= HALTED;
                                    halt_pending <= 1'b0;
                                end
                            end
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_en      = en_fire ? stage_onehot : '0;
    assign o_busy    = run ? stage_onehot : '0;
    assign o_retire  = en_fire && !sel.valid;
    assign o_stage   = stage;
    assign o_instret = instret;
    assign o_halted  = (state == HALTED);

`ifdef STAGE_SEQUENCER_PERF_EN
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] stall_cycles;

    // Counters only advance while running; they freeze in IDLE and HALTED.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cycles       <= '0;
            stall_cycles <= '0;
        end else if (run) begin
            cycles <= cycles + CNT_W'(1);
            if (i_stall) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    assign o_cycles       = cycles;
    assign o_stall_cycles = stall_cycles;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (default and MEM-dwell instances).
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stall, flush, halt;
    logic [4:0] skip_mask;

    logic [4:0]  en, busy, w_en, w_busy;
    logic [2:0]  stage, w_stage;
    logic        retire, halted, w_retire, w_halted;
    logic [31:0] instret, w_instret;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stage_sequencer dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_halt      (halt),
        .i_skip_mask (skip_mask),
        .o_en        (en),
        .o_busy      (busy),
        .o_stage     (stage),
        .o_retire    (retire),
        .o_instret   (instret),
        .o_halted    (halted)
    );

    // MEM stage (index 3) dwells two extra cycles.
    stage_sequencer #(
        .STAGE_WAIT (20'h02000)
    ) dut_w (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_halt      (halt),
        .i_skip_mask (skip_mask),
        .o_en        (w_en),
        .o_busy      (w_busy),
        .o_stage     (w_stage),
        .o_retire    (w_retire),
        .o_instret   (w_instret),
        .o_halted    (w_halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0; skip_mask = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Returns at the negedge of the first RUN cycle; caller drives inputs, then #1 and checks.
    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_en(input string tag, input logic [4:0] e, input logic r);
        #1;
        check({tag, ".en"}, 32'(en), 32'(e));
        check({tag, ".retire"}, 32'(retire), 32'(r));
    endtask

    logic [4:0] w_en_exp   [7] = '{5'h01, 5'h02, 5'h04, 5'h00, 5'h00, 5'h08, 5'h10};
    logic [4:0] w_busy_exp [7] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h10};

    initial begin
        reset = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0; skip_mask = '0;

        // Reset state
        do_reset();
        check("rst.en", 32'(en), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.stage", 32'(stage), 32'h0);
        check("rst.retire", 32'(retire), 32'h0);
        check("rst.instret", instret, 32'h0);
        check("rst.halted", 32'(halted), 32'h0);

        // Default sequencing: one stage per cycle, retire on WB
        start_run();
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            expect_en($sformatf("seq%0d", c), 5'(1 << (c % 5)), (c % 5) == 4);
        end
        @(negedge clk);
        #1;
        check("seq.instret", instret, 32'd3);
        check("seq.wrap_en", 32'(en), 32'h01);

        // MEM dwell of 3 cycles
        do_reset();
        start_run();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check($sformatf("dwell%0d.en", c), 32'(w_en), 32'(w_en_exp[c]));
            check($sformatf("dwell%0d.busy", c), 32'(w_busy), 32'(w_busy_exp[c]));
            check($sformatf("dwell%0d.retire", c), 32'(w_retire), 32'(c == 6));
        end
        @(negedge clk);
        #1;
        check("dwell.instret", w_instret, 32'd1);
        check("dwell.next_en", 32'(w_en), 32'h01);

        // Skip MEM, sampled on the EX enable cycle
        do_reset();
        start_run();
        expect_en("skip0", 5'h01, 1'b0);
        @(negedge clk);
        expect_en("skip1", 5'h02, 1'b0);
        @(negedge clk);
        skip_mask = 5'b01000;
        expect_en("skip2", 5'h04, 1'b0);
        @(negedge clk);
        skip_mask = '0;
        expect_en("skip3", 5'h10, 1'b1);
        @(negedge clk);
        #1;
        check("skip.instret", instret, 32'd1);

        // Stall for 4 cycles on EX
        do_reset();
        start_run();
        expect_en("stl0", 5'h01, 1'b0);
        @(negedge clk);
        expect_en("stl1", 5'h02, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stall = 1'b1;
            expect_en($sformatf("stall%0d", k), 5'h00, 1'b0);
            check($sformatf("stall%0d.busy", k), 32'(busy), 32'h04);
            check($sformatf("stall%0d.stage", k), 32'(stage), 32'd2);
            check($sformatf("stall%0d.instret", k), instret, 32'd0);
        end
        @(negedge clk);
        stall = 1'b0;
        expect_en("stl.release", 5'h04, 1'b0);
        @(negedge clk);
        expect_en("stl3", 5'h08, 1'b0);
        @(negedge clk);
        expect_en("stl4", 5'h10, 1'b1);

        // Flush at MEM while stalled
        @(negedge clk);
        expect_en("fl0", 5'h01, 1'b0);
        check("fl0.instret", instret, 32'd1);
        @(negedge clk);
        expect_en("fl1", 5'h02, 1'b0);
        @(negedge clk);
        expect_en("fl2", 5'h04, 1'b0);
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        expect_en("flush", 5'h00, 1'b0);
        check("flush.stage", 32'(stage), 32'd3);
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        expect_en("postflush", 5'h01, 1'b0);
        check("postflush.stage", 32'(stage), 32'd0);
        check("postflush.instret", instret, 32'd1);

        // Halt requested at ID
        @(negedge clk);
        halt = 1'b1;
        expect_en("h1", 5'h02, 1'b0);
        @(negedge clk);
        halt = 1'b0;
        expect_en("h2", 5'h04, 1'b0);
        @(negedge clk);
        expect_en("h3", 5'h08, 1'b0);
        @(negedge clk);
        expect_en("h4", 5'h10, 1'b1);
        check("h4.halted", 32'(halted), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1;
            expect_en($sformatf("halted%0d", k), 5'h00, 1'b0);
            check($sformatf("halted%0d.flag", k), 32'(halted), 32'h1);
            check($sformatf("halted%0d.busy", k), 32'(busy), 32'h0);
        end
        start = 1'b0;
        check("halted.instret", instret, 32'd2);

        do_reset();
        check("rehalt.halted", 32'(halted), 32'h0);
        check("rehalt.instret", instret, 32'h0);
        check("rehalt.stage", 32'(stage), 32'h0);
        check("rehalt.en", 32'(en), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Parametrised successor to the fixed five-stage enable generator in the multi-cycle core. Drives a one-hot stage-enable vector across NUM_STAGES stages and adds:
- per-stage multi-cycle dwell (wait states)
- per-instruction stage skipping, stall, flush and halt
- retire pulse and retired-instruction counter

Sits beside the clock generator in the core top; every stage register qualifies its update with its enable bit.

Parameters:
NUM_STAGES, 5, number of pipeline-sequence stages (2..16)
WAIT_W, 4, width of each per-stage wait-state field
STAGE_WAIT, '0 (NUM_STAGES*WAIT_W bits), packed extra dwell cycles per stage; field s = bits [s*WAIT_W +: WAIT_W]
CNT_W, 32, width of retire (and perf) counters

Ports:
i_clk  in  1  core clock
i_reset  in  1  synchronous reset, active-high
i_start  in  1  leave IDLE and begin stage 0
i_stall  in  1  freeze sequencing (external memory/VGA busy)
i_flush  in  1  abandon current instruction, restart at stage 0
i_halt  in  1  stop after current instruction retires
i_skip_mask  in  NUM_STAGES  skip stage s of current instruction when bit s=1; bit 0 ignored
o_en  out  NUM_STAGES  one-hot commit enable, high only on final dwell cycle of a stage
o_busy  out  NUM_STAGES  one-hot, high for the whole dwell of the current stage
o_stage  out  $clog2(NUM_STAGES)  current stage index
o_retire  out  1  pulse when the last executed stage of an instruction commits
o_instret  out  CNT_W  retired-instruction count
o_halted  out  1  sequencer in HALTED state

Behaviour:
- FSM states: IDLE, RUN, HALTED. Reset (sampled at i_clk edge) → IDLE; o_en=0, o_busy=0, o_stage=0, o_retire=0, o_instret=0, o_halted=0, dwell counter=0, halt_pending=0.
- IDLE: all enables 0. i_start=1 → RUN at stage 0, dwell counter=0 next cycle.
- RUN dwell: o_busy[stage]=1 every cycle. Counter increments each non-stalled cycle. o_en[stage]=1 in the cycle where counter==STAGE_WAIT[stage] (wait 0 → en in first cycle). Counter clears on stage change.
- Next-stage selection on the o_en cycle:
  - next = lowest index > stage with i_skip_mask bit 0, mask sampled that cycle.
  - If no such index, instruction completes: o_retire=1 in the same cycle as o_en, o_instret+1 (wraps at 2^CNT_W), next = 0.
- i_stall=1: o_en=0, counter and stage hold, o_busy still shows stage. Stall in the final dwell cycle delays the en/retire until stall drops.
- i_flush=1 in RUN: no en, no retire this cycle. Next cycle stage=0, counter=0.
- Priority: i_reset > i_flush > i_stall > normal.
- i_halt:
  - sets halt_pending (sticky).
  - At the next retire, go to HALTED instead of stage 0. o_halted=1, all enables 0.
  - HALTED exits only via reset. i_start is ignored outside IDLE.
- Flush clears halt_pending only if i_halt is low that cycle.
- Outputs o_en, o_retire are registered-state decodes (combinational from state/counter and i_stall/i_flush/i_skip_mask). No extra latency beyond the dwell.
- Default parameters give en order IF→ID→EX→MEM→WB, one stage per cycle, 5 cycles per instruction.

Optional Feature:
STAGE_SEQUENCER_PERF_EN:
- Defined: adds outputs o_cycles (CNT_W, counts cycles in RUN) and o_stall_cycles (CNT_W, counts RUN cycles with i_stall=1). Both reset to 0, wrap, and freeze in IDLE/HALTED.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package stage_seq_pkg holds:
  - enum seq_state_t {IDLE, RUN, HALTED}
  - stage index constants STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4
  - helper function next_stage(stage, mask)
- One natural sub-module: stage_dwell_counter (per-stage wait compare, stall hold, clear).

Test Plan:
- Reset, start, defaults: o_en 00001,00010,00100,01000,10000, then repeats. o_retire on cycle 5; o_instret=3 after 15 cycles.
- STAGE_WAIT MEM=2: o_busy[3] high 3 cycles, o_en[3] only on 3rd; instruction takes 7 cycles.
- i_skip_mask=01000 sampled at EX en: WB follows EX directly; retire after 4 cycles.
- i_stall high 4 cycles during EX's final dwell cycle: o_en=0 throughout, then o_en[2]=1 on release; instret unchanged during stall.
- i_flush at stage 3 while i_stall=1: no retire; next cycle o_stage=0, o_en[0]=1; instret unchanged.
- i_halt pulse at ID: instruction completes, o_retire=1, then o_halted=1, o_en=0 forever; i_start ignored; i_reset returns to IDLE with o_instret=0.
